// File: rtl/mux4_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux4_arb_pkg
// Shared types and constants for the 4-way round-robin mux arbiter.
//   arb_state_t : arbiter FSM state (ARB_IDLE / ARB_OWN)
//   ARB_N_REQ   : number of requesters
//   ARB_SEL_W   : width of the binary select / requester index
// ---------------------------------------------------------------------------
package mux4_arb_pkg;

    localparam int ARB_N_REQ = 4;
    localparam int ARB_SEL_W = 2;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

endpackage : mux4_arb_pkg

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin winner search over four requests.
// Search order is start+1, start+2, start+3, start (mod 4). With excl_cur set
// the start position itself is skipped, which is how the current owner is
// left out when looking for someone to hand over to.
// Ports:
//   req      in  [3:0] request vector
//   start    in  [1:0] search origin (most recent owner)
//   excl_cur in        skip the start position
//   found    out       a winner exists
//   win      out [1:0] index of the winner (0 when none found)
// ---------------------------------------------------------------------------
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [ARB_N_REQ-1:0] req,
    input  logic [ARB_SEL_W-1:0] start,
    input  logic                 excl_cur,
    output logic                 found,
    output logic [ARB_SEL_W-1:0] win
);

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= ARB_N_REQ; i++) begin
            logic [ARB_SEL_W-1:0] idx;
            // i = 4 wraps back onto start itself
            idx = start + ARB_SEL_W'(i);
            if (!found && req[idx] && !(excl_cur && (i == ARB_N_REQ))) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

endmodule : rr_pick4

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
// Round-robin arbiter sharing one 4:1 bit-select path between four
// requesters. Registers a one-hot grant and binary select each cycle, and
// registers the selected data bit one cycle later together with a valid flag.
//
// Build option: define MUX4_ARB_HOLD_LIMIT_EN to enable MAX_HOLD preemption
// (an owner is rotated out after MAX_HOLD cycles when others are waiting).
// Without it the owner keeps the grant until it drops its request and the
// hold counter does not exist.
//
// Parameters:
//   MAX_HOLD     max consecutive grant cycles while others wait (1..15)
// Ports:
//   clk          in        rising-edge clock
//   rst          in        synchronous active-high reset
//   req          in  [3:0] level requests
//   din          in  [3:0] data bit per requester
//   gnt          out [3:0] registered one-hot grant, 0 when idle
//   sel          out [1:0] registered owner index (held while idle)
//   busy         out       registered |gnt
//   dout         out       registered din[sel] of previous cycle
//   dout_vld     out       dout carries a granted bit
//
// state    | meaning
// ---------+---------------------------------------------------
// ARB_IDLE | nobody owns the path, gnt = 0
// ARB_OWN  | requester sel owns the path, exactly one gnt bit
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ARB_N_REQ-1:0] req,
    input  logic [ARB_N_REQ-1:0] din,
    output logic [ARB_N_REQ-1:0] gnt,
    output logic [ARB_SEL_W-1:0] sel,
    output logic                 busy,
    output logic                 dout,
    output logic                 dout_vld
);

    if ((MAX_HOLD < 1) || (MAX_HOLD > 15)) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be in 1..15");
    end

    arb_state_t           state_q, state_d;
    logic [ARB_N_REQ-1:0] gnt_q, gnt_d;
    logic [ARB_SEL_W-1:0] sel_q, sel_d;
    logic [ARB_SEL_W-1:0] last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic                 pick_found;
    logic [ARB_SEL_W-1:0] pick_win;

    // In OWN, last_q is always the current owner, so one search from last_q
    // covers both the idle pick and the handover pick.
    rr_pick4 u_pick (
        .req      (req),
        .start    (last_q),
        .excl_cur (state_q == ARB_OWN),
        .found    (pick_found),
        .win      (pick_win)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
        cnt_d   = cnt_q;
`endif

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_OWN;
                    gnt_d   = ARB_N_REQ'(1) << pick_win;
                    sel_d   = pick_win;
                    last_d  = pick_win;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_OWN: begin
                if (!req[sel_q]) begin
                    if (pick_found) begin
                        gnt_d  = ARB_N_REQ'(1) << pick_win;
                        sel_d  = pick_win;
                        last_d = pick_win;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                    cnt_d = '0;
`endif
                end
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    // Hold expired: rotate if anyone else waits, else restart
                    // the window for the same owner.
                    if (pick_found) begin
                        gnt_d  = ARB_N_REQ'(1) << pick_win;
                        sel_d  = pick_win;
                        last_d = pick_win;
                    end
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d     = |gnt_d;
        dout_vld_d = busy_q;
        dout_d     = busy_q & din[sel_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            last_q     <= ARB_SEL_W'(ARB_N_REQ - 1);
            busy_q     <= 1'b0;
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;

endmodule : mux4_rr_arbiter

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares a single 4:1 bit-select path between four requesters. Each cycle it decides which requester owns the path, drives the 2-bit select and a one-hot grant, and registers the selected data bit with a valid flag. It sits in front of the 4:1 mux datapath so that independent producers can time-share it fairly.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one owner keeps the grant while others wait. Legal range 1..15.
- `clk` input 1: rising-edge clock for all state.
- `rst` input 1: synchronous, active-high reset.
- `req` input [3:0]: request per requester; level-sensitive; held high while the requester wants the path.
- `din` input [3:0]: data bit per requester; `din[k]` belongs to requester k.
- `gnt` output [3:0]: registered one-hot grant, or 0 when idle.
- `sel` output [1:0]: registered binary index of the owner; drives the mux select.
- `busy` output 1: registered; equals `|gnt`.
- `dout` output 1: registered `din[sel]` of the previous cycle.
- `dout_vld` output 1: registered; high when `dout` carries a granted bit.

## Operation
- States: IDLE (`gnt`=0) and OWN (exactly one `gnt` bit set).
- Rotating priority pointer `last` (2 bits) holds the most recent owner. Search order is `last`+1, `last`+2, `last`+3, `last` (mod 4).
- IDLE: if `req`≠0, grant the first set bit in search order and go to OWN. The hold counter clears to 0. Otherwise stay in IDLE.
- OWN, owner k:
  - `req[k]`=0: pick the next winner from the remaining requests in search order starting at k+1; clear the counter. If there is no other request, go to IDLE with `gnt`=0. There is no bubble between owners.
  - `req[k]`=1 and hold not expired: keep the grant and increment the counter.
  - `req[k]`=1, hold expired (counter = `MAX_HOLD`-1), and other requests pending: rotate to the next winner in search order from k+1; clear the counter.
  - Hold expired with no other requests: keep k and clear the counter.
- On every new grant, `last` takes the new owner.
- `sel` always equals the index of the `gnt` bit. When `gnt`=0, `sel` holds its previous value.
- `dout`/`dout_vld`: each edge, `dout_vld` takes `busy` and `dout` takes `busy ? din[sel] : 0`.

## Timing
- Reset values: `gnt`=0, `sel`=0, `busy`=0, `dout`=0, `dout_vld`=0, `last`=3 (requester 0 has top priority after reset), counter=0, state IDLE.
- Request to grant: `req` sampled at edge N gives `gnt`/`sel` valid after edge N, i.e. 1-cycle latency.
- Grant to data: `dout` after edge N+1 reflects `din[sel]` sampled at edge N+1, i.e. 2 cycles after the request.
- Release: `req[k]` dropped before edge M moves the grant at edge M, either to the next requester or to 0.
- Reset mid-operation: `rst` high at an edge forces every reset value at that edge, overriding any handover. Requests are re-evaluated from the first edge with `rst` low.
- Simultaneous release by the owner and a new request from a lower-priority requester: the new request wins if it is first in search order.
- `req`=4'b1111 held continuously: owners rotate 0,1,2,3,0… with `MAX_HOLD` cycles each.

## Configuration
- `MUX4_ARB_HOLD_LIMIT_EN` defined: the `MAX_HOLD` preemption described above is active.
- Not defined: there is no preemption. The owner keeps the grant until it drops `req`, the hold counter is not built, and `MAX_HOLD` is ignored.

## Structure
- Shared package `mux4_arb_pkg` holds:
  - the state enum `arb_state_t` {ARB_IDLE, ARB_OWN};
  - the constant `ARB_N_REQ` = 4;
  - the select width `ARB_SEL_W` = 2.
- One combinational sub-module, `rr_pick4`, takes `req[3:0]`, a 2-bit start index and an exclude-current flag. It returns a found flag and the winner index. It is instantiated once.
- The grant register, `last`, the counter and the output registers live in `mux4_arb_pkg`'s user `mux4_rr_arbiter`.

## Test plan
- Reset with `req`=4'b1111 asserted → all outputs 0 while `rst`=1. First edge after release gives `gnt`=4'b0001, `sel`=0.
- `req`=4'b0100 alone with `din`=4'b0100 → `gnt`=4'b0100, `sel`=2 after 1 cycle; `dout`=1, `dout_vld`=1 one cycle later. Drop `req` → `gnt`=0 next cycle, `dout_vld`=0 the cycle after.
- Hold limit on, `MAX_HOLD`=4, `req`=4'b1111 → `gnt` sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…
- Hold limit off, `req`=4'b0011 → requester 0 keeps the grant indefinitely. Drop `req[0]` → `gnt`=4'b0010 the next cycle with no idle cycle.
- Owner 3 holding, `req`=4'b1001, drop `req[3]` → grant passes to 0 (wrap-around), `last`=0.
- Owner 1 holding, `rst` pulsed for one cycle → `gnt`=0, `last`=3. With `req`=4'b0011 the first post-reset grant is requester 0.
